// File: rtl/cc_encoder_stream.sv
// Serial systematic cyclic-code encoder: K message bits MSB first, then R parity bits
// taken from a remainder LFSR, with a one-entry holding register for gapless streaming.
module cc_encoder_stream #(
  parameter int K = 4,
  parameter int R = 3,
  parameter logic [R-1:0] GEN_POLY = 3'b011
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] msg_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_bit,
  output logic         out_sop,
  output logic         out_eop,
  output logic         busy
);
  localparam int N  = K + R;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_MSG = CW'(K - 1);
  localparam logic [CW-1:0] LAST     = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

  if (GEN_POLY[0] == 1'b0 || K < 1 || R < 1) begin : g_bad_params
    $error("cc_encoder_stream: GEN_POLY[0] must be 1 and K, R must be >= 1");
  end

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [K-1:0]   shift_q, shift_d;
  logic [R-1:0]   lfsr_q, lfsr_d;
  logic [K-1:0]   hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic           out_valid_q, out_valid_d;
  logic           out_bit_q, out_bit_d;
  logic           out_sop_q, out_sop_d;
  logic           out_eop_q, out_eop_d;
  logic           busy_q, busy_d;

  logic           accept, beat_done, need_next, load_en, fb;
  logic [K-1:0]   load_msg;

  assign in_ready  = !hold_full_q && reset;
  assign accept    = in_valid && in_ready;
  assign beat_done = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    lfsr_d      = lfsr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    load_en     = 1'b0;
    load_msg    = '0;
    fb          = 1'b0;

    if (accept) begin
      hold_d      = msg_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      MSG: begin
        if (beat_done) begin
          fb        = shift_q[K-1] ^ lfsr_q[R-1];
          lfsr_d    = (lfsr_q << 1) ^ (fb ? GEN_POLY : '0);
          shift_d   = shift_q << 1;
          count_d   = count_q + 1'b1;
          out_sop_d = 1'b0;
          out_eop_d = (count_d == LAST);
          if (count_q == LAST_MSG) begin
            state_d   = PAR;
            out_bit_d = lfsr_d[R-1];
          end else begin
            out_bit_d = shift_d[K-1];
          end
        end
      end
      PAR: begin
        if (beat_done && count_q != LAST) begin
          lfsr_d    = lfsr_q << 1;
          count_d   = count_q + 1'b1;
          out_bit_d = lfsr_d[R-1];
          out_eop_d = (count_d == LAST);
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Held message always goes first so acceptance order is kept.
    need_next = (state_q == IDLE) || (state_q == PAR && beat_done && count_q == LAST);
    if (need_next) begin
      if (hold_full_q) begin
        load_en     = 1'b1;
        load_msg    = hold_q;
        hold_full_d = accept;
      end else if (accept) begin
        load_en     = 1'b1;
        load_msg    = msg_in;
        hold_full_d = 1'b0;
      end else if (state_q == PAR) begin
        state_d     = IDLE;
        count_d     = '0;
        lfsr_d      = '0;
        out_valid_d = 1'b0;
        out_bit_d   = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
      end
    end

    if (load_en) begin
      state_d     = MSG;
      shift_d     = load_msg;
      lfsr_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b1;
      out_bit_d   = load_msg[K-1];
      out_sop_d   = 1'b1;
      out_eop_d   = 1'b0;
    end

    busy_d = (state_d != IDLE) || hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      lfsr_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      lfsr_q      <= lfsr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_cc_encoder_stream.sv
// Bench for cc_encoder_stream: directed codewords plus randomized traffic scored
// against a polynomial long-division model (default Hamming(7,4) and a K=11,R=4 instance).
module tb_cc_encoder_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_bit, out_sop, out_eop, busy;
  logic [3:0]  msg_in;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_bit, b_out_sop, b_out_eop, b_busy;
  logic [10:0] b_msg_in;

  int errors = 0;
  int checks = 0;
  bit exp_bit_q[$];
  bit exp_sop_q[$];
  bit exp_eop_q[$];

  cc_encoder_stream dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .msg_in(msg_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_sop(out_sop),
    .out_eop(out_eop), .busy(busy)
  );

  cc_encoder_stream #(.K(11), .R(4), .GEN_POLY(4'b0011)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .msg_in(b_msg_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit), .out_sop(b_out_sop),
    .out_eop(b_out_eop), .busy(b_busy)
  );

  // Codeword = msg * x^r + (msg * x^r mod g(x)), by plain long division over GF(2).
  function automatic logic [63:0] encode(int k, int r, logic [63:0] g_low, logic [63:0] msg);
    logic [63:0] rem;
    logic [63:0] g;
    rem = msg << r;
    g   = (64'd1 << r) | g_low;
    for (int i = k + r - 1; i >= r; i--)
      if (rem[i]) rem = rem ^ (g << (i - r));
    return (msg << r) | rem;
  endfunction

  task automatic push_bits(input int n, input logic [63:0] cw);
    for (int i = n - 1; i >= 0; i--) begin
      exp_bit_q.push_back(cw[i]);
      exp_sop_q.push_back(i == n - 1);
      exp_eop_q.push_back(i == 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; msg_in = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_msg_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_bit, out_sop, out_eop, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got %b want 000000", {in_ready, out_valid, out_bit, out_sop, out_eop, busy});
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_busy} !== 3'b0) begin
      errors++;
      $display("FAIL reset_state_b: got %b want 000", {b_in_ready, b_out_valid, b_busy});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL release_first_cycle: in_ready,out_valid got %b want 10", {in_ready, out_valid});
    end
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [6:0] exp_cw = 7'b1000101;
    int vcount = 0;
    msg_in = 4'b1000; in_valid = 1'b1; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL single_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        checks++;
        if (c >= 7) begin
          errors++; $display("FAIL single_extra_beat: valid at cycle %0d want idle", c);
        end else if ({out_bit, out_sop, out_eop} !== {exp_cw[6-c], c == 0, c == 6}) begin
          errors++;
          $display("FAIL single_beat%0d: bit/sop/eop got %b want %b", c, {out_bit, out_sop, out_eop}, {exp_cw[6-c], c == 0, c == 6});
        end
        vcount++;
      end
      @(negedge clk);
    end
    checks++;
    if (vcount != 7) begin
      errors++; $display("FAIL single_valid_len: got %0d want 7", vcount);
    end
    $display("test_single done: %0d valid beats", vcount);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  msgs [3] = '{4'b0001, 4'b1111, 4'b0000};
    logic [20:0] exp_all = 21'b000101111111110000000;
    int sent = 0, beat = 0, cyc = 0;
    bit saw_low = 1'b0, fire;
    in_valid = 1'b1; msg_in = msgs[0]; out_ready = 1'b1;
    while (beat < 21 && cyc < 80) begin
      fire = in_valid && in_ready;
      if (sent < 3 && !in_ready) saw_low = 1'b1;
      @(negedge clk);
      if (fire) sent++;
      in_valid = (sent < 3);
      msg_in   = msgs[sent % 3];
      if (out_valid || beat > 0) begin
        checks++;
        if (!out_valid) begin
          errors++; $display("FAIL b2b_gap: out_valid got 0 want 1 at beat %0d", beat);
        end else if ({out_bit, out_sop, out_eop} !== {exp_all[20-beat], beat % 7 == 0, beat % 7 == 6}) begin
          errors++;
          $display("FAIL b2b_beat%0d: got %b want %b", beat, {out_bit, out_sop, out_eop}, {exp_all[20-beat], beat % 7 == 0, beat % 7 == 6});
        end
        if (out_valid) beat++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (beat != 21) begin
      errors++; $display("FAIL b2b_beats: got %0d want 21", beat);
    end
    checks++;
    if (!saw_low) begin
      errors++; $display("FAIL b2b_in_ready_drop: saw_low got 0 want 1");
    end
    @(negedge clk);
    $display("test_back_to_back done: %0d beats", beat);
  endtask

  task automatic test_stall();
    logic [6:0] exp_cw = 7'b1000101;
    logic [2:0] prev = '0;
    bit prev_stall = 1'b0;
    int beat = 0, cyc = 0;
    msg_in = 4'b1000; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (beat < 7 && cyc < 60) begin
      if (prev_stall) begin
        checks++;
        if ({out_valid, out_bit, out_sop, out_eop} !== {1'b1, prev}) begin
          errors++;
          $display("FAIL stall_hold: got %b want %b", {out_valid, out_bit, out_sop, out_eop}, {1'b1, prev});
        end
      end
      out_ready = (cyc % 3 == 0);
      if (out_valid && out_ready) begin
        checks++;
        if ({out_bit, out_sop, out_eop} !== {exp_cw[6-beat], beat == 0, beat == 6}) begin
          errors++;
          $display("FAIL stall_beat%0d: got %b want %b", beat, {out_bit, out_sop, out_eop}, {exp_cw[6-beat], beat == 0, beat == 6});
        end
        beat++;
      end
      prev = {out_bit, out_sop, out_eop};
      prev_stall = out_valid && !out_ready;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (beat != 7 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_end: beats=%0d out_valid=%b want 7 and 0", beat, out_valid);
    end
    $display("test_stall done: %0d cycles", cyc);
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp_cw = 7'b0001011;
    int vcount = 0;
    msg_in = 4'b1000; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL midreset_state: out_valid,busy got %b want 00", {out_valid, busy});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL midreset_no_resume: in_ready,out_valid,busy got %b want 100", {in_ready, out_valid, busy});
    end
    msg_in = 4'b0001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (out_valid) begin
        checks++;
        if (c >= 7) begin
          errors++; $display("FAIL midreset_extra_beat: valid at cycle %0d want idle", c);
        end else if ({out_bit, out_sop, out_eop} !== {exp_cw[6-c], c == 0, c == 6}) begin
          errors++;
          $display("FAIL midreset_beat%0d: got %b want %b", c, {out_bit, out_sop, out_eop}, {exp_cw[6-c], c == 0, c == 6});
        end
        vcount++;
      end
      @(negedge clk);
    end
    checks++;
    if (vcount != 7) begin
      errors++; $display("FAIL midreset_len: got %0d want 7", vcount);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int sent = 0, cyc = 0;
    bit eb, es, ee;
    while ((sent < 40 || exp_bit_q.size() != 0) && cyc < 3000) begin
      checks++;
      if ({out_valid, busy} !== {2{exp_bit_q.size() != 0}}) begin
        errors++;
        $display("FAIL rand_valid_busy: got %b want %b (cycle %0d)", {out_valid, busy}, {2{exp_bit_q.size() != 0}}, cyc);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_bit_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected_beat: got beat want none");
        end else begin
          eb = exp_bit_q.pop_front(); es = exp_sop_q.pop_front(); ee = exp_eop_q.pop_front();
          if ({out_bit, out_sop, out_eop} !== {eb, es, ee}) begin
            errors++; $display("FAIL rand_beat: got %b want %b (cycle %0d)", {out_bit, out_sop, out_eop}, {eb, es, ee}, cyc);
          end
        end
      end
      in_valid = (sent < 40) && ($urandom_range(0, 9) < 7);
      msg_in   = 4'($urandom);
      if (in_valid && in_ready) begin
        push_bits(7, encode(4, 3, 64'h3, 64'(msg_in)));
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (sent != 40 || exp_bit_q.size() != 0) begin
      errors++; $display("FAIL rand_timeout: sent=%0d left=%0d want 40 and 0", sent, exp_bit_q.size());
    end
    $display("test_random done: %0d messages in %0d cycles", sent, cyc);
  endtask

  task automatic test_k11();
    int sent = 0, cyc = 0;
    bit eb, es, ee;
    while ((sent < 5 || exp_bit_q.size() != 0) && cyc < 500) begin
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (exp_bit_q.size() == 0) begin
          errors++; $display("FAIL k11_unexpected_beat: got beat want none");
        end else begin
          eb = exp_bit_q.pop_front(); es = exp_sop_q.pop_front(); ee = exp_eop_q.pop_front();
          if ({b_out_bit, b_out_sop, b_out_eop} !== {eb, es, ee}) begin
            errors++; $display("FAIL k11_beat: got %b want %b (cycle %0d)", {b_out_bit, b_out_sop, b_out_eop}, {eb, es, ee}, cyc);
          end
        end
      end
      b_in_valid = (sent < 5);
      b_msg_in   = (sent == 0) ? 11'b10000000000 : 11'($urandom);
      if (b_in_valid && b_in_ready) begin
        if (sent == 0) push_bits(15, 64'b100000000001001);
        else           push_bits(15, encode(11, 4, 64'h3, 64'(b_msg_in)));
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    checks++;
    if (sent != 5 || exp_bit_q.size() != 0) begin
      errors++; $display("FAIL k11_timeout: sent=%0d left=%0d want 5 and 0", sent, exp_bit_q.size());
    end
    $display("test_k11 done: %0d messages", sent);
  endtask

  task automatic test_valid_through_reset();
    int cyc = 0;
    out_ready = 1'b1;
    reset = 1'b0; in_valid = 1'b1; msg_in = 4'b0001;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      errors++; $display("FAIL vtr_in_reset: in_ready,out_valid got %b want 00", {in_ready, out_valid});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL vtr_release: in_ready,out_valid got %b want 10", {in_ready, out_valid});
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_bit, out_sop} !== 3'b101) begin
      errors++; $display("FAIL vtr_first_beat: valid,bit,sop got %b want 101", {out_valid, out_bit, out_sop});
    end
    while (out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 7) begin
      errors++; $display("FAIL vtr_len: remaining beats got %0d want 7", cyc);
    end
    $display("test_valid_through_reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    test_k11();
    test_valid_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
